// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the main-memory port arbiter.
//   MEM_ADDR_W / MEM_DATA_W : memory word address and data widths
//   state_e                 : access sequencer states
//   owner_e                 : which requester owns the current access
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int MEM_ADDR_W = 18;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb2_grant.sv
// -----------------------------------------------------------------------------
// arb2_grant
// Two-input combinational grant logic for the memory arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin on contention (the port that
// did not win last time wins); otherwise DM has fixed priority over IF.
// Ports:
//   en_i        : grants allowed (sequencer idle)
//   if_req_i    : fetch request
//   dm_req_i    : data request
//   last_win_i  : previous grant owner (MEM_ARB_RR_EN builds only)
//   if_gnt_o    : fetch grant, at most one grant high
//   dm_gnt_o    : data grant
// -----------------------------------------------------------------------------
module arb2_grant
   import mem_pkg::*;
(
   input  logic   en_i,
   input  logic   if_req_i,
   input  logic   dm_req_i,
`ifdef MEM_ARB_RR_EN
   input  owner_e last_win_i,
`endif
   output logic   if_gnt_o,
   output logic   dm_gnt_o
);

   always_comb begin
      if_gnt_o = 1'b0;
      dm_gnt_o = 1'b0;
      if (en_i) begin
`ifdef MEM_ARB_RR_EN
         if (if_req_i && dm_req_i) begin
            // Contention: hand the grant to whoever lost last time.
            if (last_win_i == OWN_DM) if_gnt_o = 1'b1;
            else                      dm_gnt_o = 1'b1;
         end else begin
            if_gnt_o = if_req_i;
            dm_gnt_o = dm_req_i;
         end
`else
         dm_gnt_o = dm_req_i;
         if_gnt_o = if_req_i & ~dm_req_i;
`endif
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port main memory between the instruction-fetch (IF) and
// data (DM) requesters. A granted access holds address/strobe for
// ACCESS_CYCLES cycles, captures read data on the last cycle, then pulses the
// owner's rvalid for one cycle (RESP) before returning to IDLE.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration with a
// last-winner flag; default is fixed DM-over-IF priority.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   if_req/if_addr                : fetch read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata     : fetch grant, response pulse, fetched word
//   dm_req/dm_we/dm_addr/dm_wdata : data request (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata     : data grant, completion pulse, load data
//   mem_*                         : memory address/data/strobes
// Handshake: a requester holds req and its payload stable until gnt; the
// grant is combinational in IDLE and the payload is registered on that edge.
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W        = MEM_ADDR_W,
   parameter int DATA_W        = MEM_DATA_W,
   parameter int ACCESS_CYCLES = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   state_e              state_q;
   owner_e              owner_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic                if_rvalid_q;
   logic                dm_rvalid_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   dm_rdata_q;
`ifdef MEM_ARB_RR_EN
   owner_e              last_win_q;
`endif

   arb2_grant u_arb2_grant (
      .en_i       (state_q == IDLE),
      .if_req_i   (if_req),
      .dm_req_i   (dm_req),
`ifdef MEM_ARB_RR_EN
      .last_win_i (last_win_q),
`endif
      .if_gnt_o   (if_gnt),
      .dm_gnt_o   (dm_gnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
         last_win_q  <= OWN_IF;
`endif
      end else begin
         // rvalid is a one-cycle pulse; only the ACCESS->RESP edge sets it.
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (dm_gnt || if_gnt) begin
                  owner_q     <= dm_gnt ? OWN_DM : OWN_IF;
                  addr_q      <= dm_gnt ? dm_addr : if_addr;
                  if (dm_gnt) wdata_q <= dm_wdata;
                  // Strobes are registered so they rise together with the
                  // registered address at the start of ACCESS.
                  mem_write_q <= dm_gnt & dm_we;
                  mem_read_q  <= ~(dm_gnt & dm_we);
                  cnt_q       <= '0;
                  state_q     <= ACCESS;
`ifdef MEM_ARB_RR_EN
                  last_win_q  <= dm_gnt ? OWN_DM : OWN_IF;
`endif
               end
            end
            ACCESS: begin
               if (cnt_q == CNT_LAST) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= RESP;
                  if (owner_q == OWN_DM) begin
                     dm_rvalid_q <= 1'b1;
                     // A write completion reports zero load data.
                     dm_rdata_q  <= mem_write_q ? '0 : mem_read_data;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= mem_read_data;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign if_rvalid      = if_rvalid_q;
   assign dm_rvalid      = dm_rvalid_q;
   assign if_rdata       = if_rdata_q;
   assign dm_rdata       = dm_rdata_q;

endmodule
